// File: rtl/nubus_arb_ctrl_pkg.sv
// rtl/nubus_arb_ctrl_pkg.sv - shared types and constants for the NuBus arbitration controller
package nubus_arb_ctrl_pkg;

  // Controller states: released, contesting, granted-awaiting-start, owning a tenure
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2,
    ST_OWN   = 2'd3
  } arb_state_t;

  localparam int DEF_ID_W   = 4;
  localparam int DEF_SETTLE = 2;

  // Open-collector driver control levels
  localparam logic DRIVE   = 1'b0;
  localparam logic RELEASE = 1'b1;

  // Settle counter width; it saturates at SETTLE so it never needs to wrap
  function automatic int cnt_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/nubus_arb_ctrl_if.sv
// rtl/nubus_arb_ctrl_if.sv - bus-side and master-side signal bundle for the arbitration controller
interface nubus_arb_ctrl_if
  import nubus_arb_ctrl_pkg::*;
#(
  parameter int ID_W = DEF_ID_W
);

  logic [ID_W-1:0] idn;
  logic [ID_W-1:0] arbn;
  logic [ID_W-1:0] arbon;
  logic            rqstn;
  logic            rqston;
  logic            startn;
  logic            ackn;
  logic            req_i;
  logic            lock_i;
  logic            tx_start_i;
  logic            tx_done_i;
  logic            grant_o;
  logic            busy_o;

  // Controller side
  modport slave (
    input  idn, arbn, rqstn, startn, ackn,
    input  req_i, lock_i, tx_start_i, tx_done_i,
    output arbon, rqston, grant_o, busy_o
  );

  // Environment side: card master plus the sensed bus lines
  modport master (
    output idn, arbn, rqstn, startn, ackn,
    output req_i, lock_i, tx_start_i, tx_done_i,
    input  arbon, rqston, grant_o, busy_o
  );

endinterface

// File: rtl/nubus_arb_contest.sv
// rtl/nubus_arb_contest.sv - combinational ARB* contest logic generalised to ID_W bits
module nubus_arb_contest
  import nubus_arb_ctrl_pkg::*;
#(
  parameter int ID_W = DEF_ID_W
) (
  input  logic [ID_W-1:0] idn,
  input  logic [ID_W-1:0] arbn,
  input  logic            en,
  output logic [ID_W-1:0] arbon,
  output logic            win
);

  // A bit is lost when our ID bit is 0 (idn=1) but someone pulls that ARB* line low
  logic [ID_W-1:0] lose;
  logic [ID_W:0]   lost_at_or_above;

  assign lose = idn & ~arbn;

  // Prefix-OR from the MSB down: lost_at_or_above[k] = any lost bit j >= k
  always_comb begin
    lost_at_or_above       = '0;
    lost_at_or_above[ID_W] = 1'b0;
    for (int k = ID_W - 1; k >= 0; k--) begin
      lost_at_or_above[k] = lost_at_or_above[k+1] | lose[k];
    end
  end

  // Drive only our asserted ID bits, and back off below the highest lost bit
  always_comb begin
    arbon = {ID_W{RELEASE}};
    for (int k = 0; k < ID_W; k++) begin
      if (en && !idn[k] && !lost_at_or_above[k+1]) begin
        arbon[k] = DRIVE;
      end
    end
    win = en & ~lost_at_or_above[0];
  end

endmodule

// File: rtl/nubus_arb_ctrl.sv
// rtl/nubus_arb_ctrl.sv - clocked NuBus master-arbitration controller (FSM, settle, busy, fairness, lock)
module nubus_arb_ctrl
  import nubus_arb_ctrl_pkg::*;
#(
  parameter int ID_W   = DEF_ID_W,
  parameter int SETTLE = DEF_SETTLE,
  parameter bit FAIR   = 1'b1
) (
  input logic           nub_clkn,
  input logic           nub_resetn,
  nubus_arb_ctrl_if.slave bus
);

  localparam int              CNT_W   = cnt_width(SETTLE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE);

  arb_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             fair_blk, fair_nx;
  logic             busy_q;
  logic             grant_q;
  logic             contest_en;
  logic             rqst_drive;
  logic             win;
  logic [ID_W-1:0]  contest_arbon;

  nubus_arb_contest #(.ID_W(ID_W)) u_contest (
    .idn   (bus.idn),
    .arbn  (bus.arbn),
    .en    (contest_en),
    .arbon (contest_arbon),
    .win   (win)
  );

  // Next state, settle counter, fairness latch and driver enables
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    fair_nx    = fair_blk;
    contest_en = 1'b0;
    rqst_drive = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.rqstn) begin
          fair_nx = 1'b0;
        end
        if (bus.req_i && !(FAIR && fair_blk)) begin
          state_nx = ST_ARB;
          cnt_nx   = '0;
        end
      end
      ST_ARB: begin
        contest_en = 1'b1;
        rqst_drive = 1'b1;
        if (!bus.req_i) begin
          state_nx = ST_IDLE;
        end else if (!bus.startn) begin
          // Someone else started a tenure; settle again for the next one
          cnt_nx = '0;
        end else if (cnt == CNT_MAX) begin
          if (win && !busy_q) begin
            state_nx = ST_GRANT;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_GRANT: begin
        contest_en = 1'b1;
        rqst_drive = 1'b1;
        if (bus.tx_start_i) begin
          state_nx = ST_OWN;
        end else if (!bus.req_i) begin
          state_nx = ST_IDLE;
        end
      end
      ST_OWN: begin
        // A locked sequence keeps ARB*/RQST* asserted so nobody can slip in
        contest_en = bus.lock_i;
        rqst_drive = bus.lock_i;
        if (bus.tx_done_i) begin
          if (bus.lock_i && bus.req_i) begin
            state_nx = ST_GRANT;
          end else begin
            state_nx = ST_IDLE;
            fair_nx  = FAIR;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State, counter, fairness and registered grant
  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      fair_blk <= 1'b0;
      grant_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      fair_blk <= fair_nx;
      grant_q  <= (state_nx == ST_GRANT) || (state_nx == ST_OWN);
    end
  end

  // Bus tenure tracker: START* opens, ACK* closes and wins a same-cycle tie
  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      busy_q <= 1'b0;
    end else if (!bus.ackn) begin
      busy_q <= 1'b0;
    end else if (!bus.startn) begin
      busy_q <= 1'b1;
    end
  end

  assign bus.arbon   = contest_arbon;
  assign bus.rqston  = rqst_drive ? DRIVE : RELEASE;
  assign bus.grant_o = grant_q;
  assign bus.busy_o  = busy_q;

endmodule

// File: tb/tb_nubus_arb_ctrl.sv
// tb/tb_nubus_arb_ctrl.sv - directed bench running ID_W=4 and ID_W=6 controllers in lockstep
module tb_nubus_arb_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] idn;
  logic [5:0] arbn;
  logic       rqstn, startn, ackn, req, lock, txs, txd;
  int         total;
  int         bad;

  nubus_arb_ctrl_if #(.ID_W(4)) if4 ();
  nubus_arb_ctrl_if #(.ID_W(6)) if6 ();

  assign if4.idn        = idn[3:0];
  assign if4.arbn       = arbn[3:0];
  assign if4.rqstn      = rqstn;
  assign if4.startn     = startn;
  assign if4.ackn       = ackn;
  assign if4.req_i      = req;
  assign if4.lock_i     = lock;
  assign if4.tx_start_i = txs;
  assign if4.tx_done_i  = txd;

  assign if6.idn        = idn;
  assign if6.arbn       = arbn;
  assign if6.rqstn      = rqstn;
  assign if6.startn     = startn;
  assign if6.ackn       = ackn;
  assign if6.req_i      = req;
  assign if6.lock_i     = lock;
  assign if6.tx_start_i = txs;
  assign if6.tx_done_i  = txd;

  nubus_arb_ctrl #(.ID_W(4), .SETTLE(2), .FAIR(1'b1)) dut4 (
    .nub_clkn   (clk),
    .nub_resetn (rst_n),
    .bus        (if4)
  );

  nubus_arb_ctrl #(.ID_W(6), .SETTLE(2), .FAIR(1'b1)) dut6 (
    .nub_clkn   (clk),
    .nub_resetn (rst_n),
    .bus        (if6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic st(input string tag, input logic [3:0] a4, input logic [5:0] a6,
                    input logic rq, input logic gr);
    chk({tag, " arbon4"}, 32'(if4.arbon), 32'(a4));
    chk({tag, " arbon6"}, 32'(if6.arbon), 32'(a6));
    chk({tag, " rqston4"}, 32'(if4.rqston), 32'(rq));
    chk({tag, " rqston6"}, 32'(if6.rqston), 32'(rq));
    chk({tag, " grant4"}, 32'(if4.grant_o), 32'(gr));
    chk({tag, " grant6"}, 32'(if6.grant_o), 32'(gr));
  endtask

  task automatic bz(input string tag, input logic b);
    chk({tag, " busy4"}, 32'(if4.busy_o), 32'(b));
    chk({tag, " busy6"}, 32'(if6.busy_o), 32'(b));
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    idn    = 6'b000001;
    arbn   = 6'b111111;
    rqstn  = 1'b1;
    startn = 1'b1;
    ackn   = 1'b1;
    req    = 1'b0;
    lock   = 1'b0;
    txs    = 1'b0;
    txd    = 1'b0;
    #12;
    st("reset", 4'b1111, 6'b111111, 1'b1, 1'b0);
    bz("reset", 1'b0);
    rst_n = 1'b1;

    // Slot E on an idle bus: grant four clocks after req
    req = 1'b1;
    step(); #1;
    st("t1 arb", 4'b0001, 6'b000001, 1'b0, 1'b0);
    arbn = 6'b000001;
    step();
    step();
    st("t1 settle", 4'b0001, 6'b000001, 1'b0, 1'b0);
    step();
    st("t1 grant", 4'b0001, 6'b000001, 1'b0, 1'b1);

    // Unlocked tenure, then fairness hold until RQST* is seen released
    txs = 1'b1;
    step(); txs = 1'b0; #1;
    st("t4 own", 4'b1111, 6'b111111, 1'b1, 1'b1);
    rqstn = 1'b0;
    txd = 1'b1;
    step(); txd = 1'b0; #1;
    st("t4 done", 4'b1111, 6'b111111, 1'b1, 1'b0);
    step();
    step();
    st("t4 blocked", 4'b1111, 6'b111111, 1'b1, 1'b0);
    rqstn = 1'b1;
    step(); rqstn = 1'b0; #1;
    st("t4 clear", 4'b1111, 6'b111111, 1'b1, 1'b0);
    step();
    st("t4 rearb", 4'b0001, 6'b000001, 1'b0, 1'b0);
    req = 1'b0;
    step();
    st("t4 drop", 4'b1111, 6'b111111, 1'b1, 1'b0);
    rqstn = 1'b1;

    // Slot D contesting against slot E
    idn  = 6'b000010;
    arbn = 6'b111111;
    req  = 1'b1;
    step(); #1;
    st("t2 arb", 4'b0010, 6'b000010, 1'b0, 1'b0);
    arbn = 6'b000001;
    #1;
    st("t2 lose", 4'b0011, 6'b000011, 1'b0, 1'b0);
    repeat (5) step();
    st("t2 nogrant", 4'b0011, 6'b000011, 1'b0, 1'b0);
    arbn = 6'b000010;
    #1;
    step();
    st("t2 grant", 4'b0010, 6'b000010, 1'b0, 1'b1);
    req = 1'b0;
    step();
    st("t2 drop", 4'b1111, 6'b111111, 1'b1, 1'b0);

    // Winning while another master's tenure is in progress
    idn    = 6'b000001;
    arbn   = 6'b000001;
    req    = 1'b1;
    startn = 1'b0;
    step(); startn = 1'b1; #1;
    bz("t3 start", 1'b1);
    st("t3 arb", 4'b0001, 6'b000001, 1'b0, 1'b0);
    repeat (4) step();
    st("t3 held", 4'b0001, 6'b000001, 1'b0, 1'b0);
    ackn = 1'b0;
    step(); ackn = 1'b1; #1;
    bz("t3 ack", 1'b0);
    st("t3 ack", 4'b0001, 6'b000001, 1'b0, 1'b0);
    step();
    st("t3 grant", 4'b0001, 6'b000001, 1'b0, 1'b1);

    // Locked sequence: two tenures without dropping drivers or grant
    lock = 1'b1;
    txs = 1'b1;
    step(); txs = 1'b0; #1;
    st("t5 own1", 4'b0001, 6'b000001, 1'b0, 1'b1);
    txd = 1'b1;
    step(); txd = 1'b0; #1;
    st("t5 grant1", 4'b0001, 6'b000001, 1'b0, 1'b1);
    txs = 1'b1;
    step(); txs = 1'b0; #1;
    st("t5 own2", 4'b0001, 6'b000001, 1'b0, 1'b1);
    txd = 1'b1;
    step(); txd = 1'b0; #1;
    st("t5 grant2", 4'b0001, 6'b000001, 1'b0, 1'b1);
    txs = 1'b1;
    step(); txs = 1'b0; #1;
    st("t5 own3", 4'b0001, 6'b000001, 1'b0, 1'b1);

    // Asynchronous reset while owning a locked tenure
    rst_n = 1'b0;
    #1;
    st("t6 reset", 4'b1111, 6'b111111, 1'b1, 1'b0);
    bz("t6 reset", 1'b0);
    lock = 1'b0;
    req  = 1'b0;
    #1;
    rst_n = 1'b1;

    // Stray strobes while idle change nothing
    txs = 1'b1;
    txd = 1'b1;
    step(); txs = 1'b0; txd = 1'b0; #1;
    st("idle strobes", 4'b1111, 6'b111111, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
